// File: rtl/rrb_req_agent_if.sv
// rrb_req_agent_if: job, arbiter and shared-bus signals of the request agent.
interface rrb_req_agent_if #(
    parameter int CHANNELS  = 8,
    parameter int BURST_LEN = 4
);
    localparam int CH_W   = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int BEAT_W = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    logic [CHANNELS-1:0] job_push;
    logic [CHANNELS-1:0] job_full;
    logic [CHANNELS-1:0] request;
    logic [CHANNELS-1:0] grant;
    logic                bus_valid;
    logic [CH_W-1:0]     bus_ch;
    logic [BEAT_W-1:0]   bus_beat;
    logic                bus_last;
    logic                bus_ready;
    logic                done;
    logic                err_grant;
    modport master (
        output job_push, grant, bus_ready,
        input  job_full, request, bus_valid, bus_ch, bus_beat, bus_last, done, err_grant
    );
    modport slave (
        input  job_push, grant, bus_ready,
        output job_full, request, bus_valid, bus_ch, bus_beat, bus_last, done, err_grant
    );
endinterface

// File: rtl/rrb_req_agent.sv
// rrb_req_agent: per-channel pending-job counters feeding a round-robin arbiter and a burst bus.
module rrb_req_agent #(
    parameter int CHANNELS  = 8,
    parameter int CNT_W     = 4,
    parameter int BURST_LEN = 4,
    localparam int CH_W     = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int BEAT_W   = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1
) (
    input logic            clk,
    input logic            reset,
    rrb_req_agent_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    localparam logic [CNT_W-1:0]  MAX_CNT   = '1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_pending [CHANNELS];
    logic [CNT_W-1:0]    w_pending_nx [CHANNELS];
    logic [CHANNELS-1:0] r_request, w_nz, w_nz_nx, w_full;
    logic [CH_W-1:0]     r_ch, w_gnt_idx;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_err, w_last, w_fin, w_onehot, w_legal;

    assign w_last   = r_state == XFER && r_beat == LAST_BEAT;
    assign w_fin    = w_last && bus.bus_ready;
    assign w_onehot = bus.grant != '0 && (bus.grant & (bus.grant - CHANNELS'(1))) == '0;
    assign w_legal  = w_onehot && |(bus.grant & w_nz);

    // A push and a decrement in the same cycle cancel, even on a full counter.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.grant[i]) w_gnt_idx = CH_W'(i);
            w_nz[i]   = r_pending[i] != '0;
            w_full[i] = r_pending[i] == MAX_CNT;
            w_pending_nx[i] = (bus.job_push[i] && w_fin && r_ch == CH_W'(i)) ? r_pending[i] :
                              bus.job_push[i] ? (w_full[i] ? r_pending[i] : r_pending[i] + 1'b1) :
                              (w_fin && r_ch == CH_W'(i)) ? r_pending[i] - 1'b1 : r_pending[i];
            w_nz_nx[i] = w_pending_nx[i] != '0;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_state_nx = (r_state == IDLE && w_legal) ? XFER :
                     (r_state == XFER && w_fin)   ? DONE :
                     (r_state == DONE)            ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_request <= '0;
            r_ch      <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) r_pending[i] <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_request <= w_state_nx == IDLE ? w_nz_nx : '0;
            r_err     <= r_err | (r_state == IDLE && bus.grant != '0 && !w_legal);
            if (r_state == IDLE && w_legal) begin
                r_ch   <= w_gnt_idx;
                r_beat <= '0;
            end else if (r_state == XFER && bus.bus_ready && !w_last) begin
                r_beat <= r_beat + 1'b1;
            end
            for (int i = 0; i < CHANNELS; i++) r_pending[i] <= w_pending_nx[i];
        end
    end

    assign bus.job_full  = w_full;
    assign bus.request   = r_request;
    assign bus.bus_valid = r_state == XFER;
    assign bus.bus_ch    = r_ch;
    assign bus.bus_beat  = r_beat;
    assign bus.bus_last  = w_last;
    assign bus.done      = r_state == DONE;
    assign bus.err_grant = r_err;
endmodule

// File: tb/tb_rrb_req_agent.sv
// tb_rrb_req_agent: directed stimulus with a scoreboard of expected bus beats and done pulses.
module tb_rrb_req_agent;
    typedef logic [6:0] ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arb_en = 1'b0;
    logic [7:0] tb_grant = '0;
    logic [7:0] arb_grant;
    logic [2:0] ptr, arb_idx, idx;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_done;
    ev_t        q[$];
    ev_t        mon_o, mon_e;

    rrb_req_agent_if #(.CHANNELS(8), .BURST_LEN(4)) intf ();
    rrb_req_agent #(.CHANNELS(8), .CNT_W(4), .BURST_LEN(4)) dut (.clk(clk), .reset(reset), .bus(intf));

    always #5 clk = ~clk;
    assign intf.grant = arb_en ? arb_grant : tb_grant;

    always_comb begin
        arb_grant = '0;
        arb_idx   = '0;
        idx       = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (intf.request[idx]) begin
                arb_grant = 8'(1) << idx;
                arb_idx   = idx;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (arb_en && arb_grant != '0) ptr <= arb_idx + 3'd1;
    end

    function automatic ev_t mk(bit d, int ch, int b, bit l);
        return {d, 3'(ch), 2'(b), l};
    endfunction

    always @(negedge clk) begin
        if (!reset && ((intf.bus_valid && intf.bus_ready) || intf.done)) begin
            mon_o = intf.done ? mk(1'b1, int'(intf.bus_ch), 0, 1'b0)
                              : {1'b0, intf.bus_ch, intf.bus_beat, intf.bus_last};
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got %h required no event", mon_o);
            end else begin
                mon_e = q.pop_front();
                if (mon_o !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb_event: got %h required %h", mon_o, mon_e);
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        intf.job_push = '0;
        intf.bus_ready = 1'b1;
        tb_grant = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(int ch);
        intf.job_push = 8'(1) << ch;
        tick();
        intf.job_push = '0;
    endtask

    task automatic expect_burst(int ch);
        for (int b = 0; b < 4; b++) q.push_back(mk(1'b0, ch, b, b == 3));
        q.push_back(mk(1'b1, ch, 0, 1'b0));
    endtask

    task automatic run_burst(int ch, bit push_last);
        chk("burst_req", 32'(intf.request[ch]), 1);
        expect_burst(ch);
        tb_grant = 8'(1) << ch;
        tick();
        tb_grant = 8'hFF;
        repeat (3) tick();
        chk("burst_last", 32'(intf.bus_last), 1);
        if (push_last) intf.job_push = 8'(1) << ch;
        tick();
        intf.job_push = '0;
        tb_grant = '0;
        chk("burst_done", 32'(intf.done), 1);
        chk("burst_valid_done", 32'(intf.bus_valid), 0);
        tick();
    endtask

    initial begin
        intf.job_push = '0;
        intf.bus_ready = 1'b1;
        tick();
        do_reset();
        chk("rst_request", 32'(intf.request), 0);
        chk("rst_valid", 32'(intf.bus_valid), 0);
        chk("rst_ch", 32'(intf.bus_ch), 0);
        chk("rst_beat", 32'(intf.bus_beat), 0);
        chk("rst_last", 32'(intf.bus_last), 0);
        chk("rst_done", 32'(intf.done), 0);
        chk("rst_err", 32'(intf.err_grant), 0);
        chk("rst_full", 32'(intf.job_full), 0);

        push(2);
        chk("single_req", 32'(intf.request), 32'h04);
        run_burst(2, 1'b0);
        chk("single_req_after", 32'(intf.request), 0);
        chk("single_err", 32'(intf.err_grant), 0);

        do_reset();
        push(3);
        expect_burst(3);
        tb_grant = 8'h08;
        tick();
        tb_grant = '0;
        tick();
        intf.bus_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_beat", 32'(intf.bus_beat), 1);
            chk("bp_valid", 32'(intf.bus_valid), 1);
        end
        intf.bus_ready = 1'b1;
        repeat (3) tick();
        chk("bp_done", 32'(intf.done), 1);
        tick();
        chk("bp_req_after", 32'(intf.request), 0);

        do_reset();
        intf.job_push = 8'h01;
        repeat (14) tick();
        chk("sat_full_14", 32'(intf.job_full[0]), 0);
        repeat (2) tick();
        intf.job_push = '0;
        chk("sat_full_16", 32'(intf.job_full[0]), 1);
        run_burst(0, 1'b1);
        chk("sat_push_on_last", 32'(intf.job_full[0]), 1);
        run_burst(0, 1'b0);
        chk("sat_after_dec", 32'(intf.job_full[0]), 0);
        chk("sat_req", 32'(intf.request), 32'h01);

        do_reset();
        tb_grant = 8'h03;
        tick();
        tb_grant = '0;
        chk("ill_multi_err", 32'(intf.err_grant), 1);
        chk("ill_multi_valid", 32'(intf.bus_valid), 0);
        tick();
        chk("ill_sticky", 32'(intf.err_grant), 1);
        do_reset();
        chk("ill_rst_err", 32'(intf.err_grant), 0);
        tb_grant = 8'h10;
        tick();
        tb_grant = '0;
        chk("ill_empty_err", 32'(intf.err_grant), 1);
        tick();
        chk("ill_empty_valid", 32'(intf.bus_valid), 0);

        do_reset();
        intf.job_push = 8'h40;
        repeat (2) tick();
        intf.job_push = '0;
        q.push_back(mk(1'b0, 6, 0, 1'b0));
        q.push_back(mk(1'b0, 6, 1, 1'b0));
        tb_grant = 8'h40;
        tick();
        tb_grant = '0;
        repeat (2) tick();
        chk("mid_beat2", 32'(intf.bus_beat), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", 32'(intf.bus_valid), 0);
        chk("mid_beat", 32'(intf.bus_beat), 0);
        chk("mid_ch", 32'(intf.bus_ch), 0);
        chk("mid_done", 32'(intf.done), 0);
        chk("mid_req", 32'(intf.request), 0);
        tick();
        chk("mid_pending_clear", 32'(intf.request), 0);

        do_reset();
        intf.job_push = 8'hA2;
        tick();
        intf.job_push = '0;
        chk("rr_req", 32'(intf.request), 32'hA2);
        expect_burst(1);
        expect_burst(5);
        expect_burst(7);
        arb_en = 1'b1;
        n_done = 0;
        for (int c = 0; c < 60 && n_done < 3; c++) begin
            tick();
            if (intf.done) n_done++;
        end
        chk("rr_done_count", 32'(n_done), 3);
        tick();
        arb_en = 1'b0;
        chk("rr_req_after", 32'(intf.request), 0);
        chk("rr_err", 32'(intf.err_grant), 0);

        tick();
        chk("sb_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
